// File: rtl/rtc_pkg.sv
// Shared field widths, field limits and the month-length helper for the RTC calendar.
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 7;

    localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MON_W-1:0]  MAX_MON  = 4'd12;
    localparam logic [YEAR_W-1:0] MAX_YEAR = 7'd99;

    // Out-of-range months return 31; callers reject those months separately.
    function automatic logic [DAY_W-1:0] month_len(
        input logic [MON_W-1:0]  month,
        input logic [YEAR_W-1:0] year,
        input logic              leap_en
    );
        logic [DAY_W-1:0] len;
        len = 5'd31;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            4'd2:                    len = (leap_en && (year[1:0] == 2'b00)) ? 5'd29 : 5'd28;
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the board clock down to the calendar advance rate; adv is high on the advancing edge.
module rtc_prescaler #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_HZ = 1,
    parameter int FAST_HZ = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic fast,
    input  logic clear,
    output logic adv
);

    localparam int DIV_N   = CLK_HZ / TICK_HZ;
    localparam int DIV_F   = CLK_HZ / FAST_HZ;
    localparam int DIV_MAX = (DIV_N > DIV_F) ? DIV_N : DIV_F;
    localparam int CNT_W   = $clog2(DIV_MAX);

    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(DIV_N - 1);
    localparam logic [CNT_W-1:0] LAST_F = CNT_W'(DIV_F - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] last;

    assign last = fast ? LAST_F : LAST_N;

    // >= so that switching to the fast divisor mid-count never overshoots.
    assign adv = run && (count_reg >= last);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (run) begin
            count_next = adv ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rtc_calendar.sv
// Real-time clock/calendar: hh:mm:ss, day, month, year counters with validated load and tick pulse.
module rtc_calendar
    import rtc_pkg::*;
#(
    parameter int CLK_HZ    = 10_000_000,
    parameter int TICK_HZ   = 1,
    parameter int FAST_HZ   = 5,
    parameter int YEAR_BASE = 2000
) (
    input  logic              ADC_CLK_10,
    input  logic              reset,
    input  logic              run,
    input  logic              fast,
    input  logic              leap_en,
    input  logic              load,
    input  logic [SEC_W-1:0]  ld_sec,
    input  logic [SEC_W-1:0]  ld_min,
    input  logic [HOUR_W-1:0] ld_hour,
    input  logic [DAY_W-1:0]  ld_day,
    input  logic [MON_W-1:0]  ld_month,
    input  logic [YEAR_W-1:0] ld_year,
    output logic [SEC_W-1:0]  sec,
    output logic [SEC_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [DAY_W-1:0]  day,
    output logic [MON_W-1:0]  month,
    output logic [YEAR_W-1:0] year,
    output logic              tick,
    output logic              load_err
);

    // Leap rule year[1:0]==0 only holds when year 0 is a multiple of 400.
    if ((CLK_HZ / TICK_HZ) < 2 || (CLK_HZ / FAST_HZ) < 2 || FAST_HZ < TICK_HZ
        || (YEAR_BASE % 400) != 0) begin : g_bad_params
        $error("rtc_calendar: illegal parameter set");
    end

    logic [SEC_W-1:0]  sec_reg,   sec_next;
    logic [SEC_W-1:0]  min_reg,   min_next;
    logic [HOUR_W-1:0] hour_reg,  hour_next;
    logic [DAY_W-1:0]  day_reg,   day_next;
    logic [MON_W-1:0]  month_reg, month_next;
    logic [YEAR_W-1:0] year_reg,  year_next;
    logic              tick_reg;
    logic              load_err_reg;

    logic ld_ok;
    logic load_ok;
    logic load_bad;
    logic adv;
    logic step;

    assign ld_ok = (ld_sec <= MAX_SEC) && (ld_min <= MAX_SEC) && (ld_hour <= MAX_HOUR)
                && (ld_day != '0) && (ld_month != '0) && (ld_month <= MAX_MON)
                && (ld_year <= MAX_YEAR)
                && (ld_day <= month_len(ld_month, ld_year, leap_en));

    assign load_ok  = load && ld_ok;
    assign load_bad = load && !ld_ok;
    assign step     = adv && !load_ok;

    rtc_prescaler #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .FAST_HZ(FAST_HZ)
    ) u_prescaler (
        .clk  (ADC_CLK_10),
        .reset(reset),
        .run  (run),
        .fast (fast),
        .clear(load_ok),
        .adv  (adv)
    );

    // Whole carry chain resolves in one edge; >= keeps any odd state from sticking.
    always_comb begin
        sec_next   = sec_reg;
        min_next   = min_reg;
        hour_next  = hour_reg;
        day_next   = day_reg;
        month_next = month_reg;
        year_next  = year_reg;
        if (load_ok) begin
            sec_next   = ld_sec;
            min_next   = ld_min;
            hour_next  = ld_hour;
            day_next   = ld_day;
            month_next = ld_month;
            year_next  = ld_year;
        end else if (step) begin
            if (sec_reg >= MAX_SEC) begin
                sec_next = '0;
                if (min_reg >= MAX_SEC) begin
                    min_next = '0;
                    if (hour_reg >= MAX_HOUR) begin
                        hour_next = '0;
                        if (day_reg >= month_len(month_reg, year_reg, leap_en)) begin
                            day_next = 5'd1;
                            if (month_reg >= MAX_MON) begin
                                month_next = 4'd1;
                                year_next  = (year_reg >= MAX_YEAR) ? '0 : year_reg + 1'b1;
                            end else begin
                                month_next = month_reg + 1'b1;
                            end
                        end else begin
                            day_next = day_reg + 1'b1;
                        end
                    end else begin
                        hour_next = hour_reg + 1'b1;
                    end
                end else begin
                    min_next = min_reg + 1'b1;
                end
            end else begin
                sec_next = sec_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (reset) begin
            sec_reg      <= '0;
            min_reg      <= '0;
            hour_reg     <= '0;
            day_reg      <= 5'd1;
            month_reg    <= 4'd1;
            year_reg     <= '0;
            tick_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            sec_reg      <= sec_next;
            min_reg      <= min_next;
            hour_reg     <= hour_next;
            day_reg      <= day_next;
            month_reg    <= month_next;
            year_reg     <= year_next;
            tick_reg     <= step;
            load_err_reg <= load_bad;
        end
    end

    assign sec      = sec_reg;
    assign min      = min_reg;
    assign hour     = hour_reg;
    assign day      = day_reg;
    assign month    = month_reg;
    assign year     = year_reg;
    assign tick     = tick_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed self-checking bench for rtc_calendar with CLK_HZ=20 (DIV_N=20, DIV_F=4).
module tb_rtc_calendar;

    logic       ADC_CLK_10 = 1'b0;
    logic       reset, run, fast, leap_en, load;
    logic [5:0] ld_sec, ld_min;
    logic [4:0] ld_hour, ld_day;
    logic [3:0] ld_month;
    logic [6:0] ld_year;
    logic [5:0] sec, min;
    logic [4:0] hour, day;
    logic [3:0] month;
    logic [6:0] year;
    logic       tick, load_err;

    int errors   = 0;
    int checks   = 0;
    int tick_cnt = 0;

    logic [32:0] now_t;
    assign now_t = {hour, min, sec, day, month, year};

    always #5 ADC_CLK_10 = ~ADC_CLK_10;

    rtc_calendar #(
        .CLK_HZ(20), .TICK_HZ(1), .FAST_HZ(5), .YEAR_BASE(2000)
    ) dut (
        .ADC_CLK_10(ADC_CLK_10), .reset(reset), .run(run), .fast(fast),
        .leap_en(leap_en), .load(load),
        .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
        .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
        .tick(tick), .load_err(load_err)
    );

    function automatic logic [32:0] pk(input int h, input int mi, input int s,
                                       input int d, input int mo, input int y);
        return {5'(h), 6'(mi), 6'(s), 5'(d), 4'(mo), 7'(y)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ADC_CLK_10);
            #1;
            if (tick === 1'b1) tick_cnt++;
        end
    endtask

    task automatic set_ld(input int h, input int mi, input int s,
                          input int d, input int mo, input int y);
        ld_hour = 5'(h); ld_min = 6'(mi); ld_sec = 6'(s);
        ld_day = 5'(d); ld_month = 4'(mo); ld_year = 7'(y);
    endtask

    task automatic test_reset;
        reset = 1; run = 0; fast = 0; leap_en = 0; load = 0;
        set_ld(0, 0, 0, 1, 1, 0);
        step(3);
        checks++;
        if (now_t !== pk(0, 0, 0, 1, 1, 0)) begin
            errors++; $display("FAIL reset_fields: got %h want %h", now_t, pk(0, 0, 0, 1, 1, 0));
        end
        checks++;
        if (tick !== 1'b0 || load_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got tick=%b load_err=%b want 0 0", tick, load_err);
        end
        reset = 0;
        $display("test_reset done: time=%h", now_t);
    endtask

    task automatic test_normal_rate;
        run = 1; fast = 0; tick_cnt = 0;
        step(19);
        checks++;
        if (now_t !== pk(0, 0, 0, 1, 1, 0) || tick_cnt != 0) begin
            errors++; $display("FAIL normal_early: got %h ticks=%0d want %h ticks=0", now_t, tick_cnt, pk(0, 0, 0, 1, 1, 0));
        end
        step(1);
        checks++;
        if (now_t !== pk(0, 0, 1, 1, 1, 0) || tick !== 1'b1) begin
            errors++; $display("FAIL normal_edge20: got %h tick=%b want %h tick=1", now_t, tick, pk(0, 0, 1, 1, 1, 0));
        end
        step(1);
        checks++;
        if (tick !== 1'b0 || tick_cnt != 1) begin
            errors++; $display("FAIL normal_tick_once: got tick=%b ticks=%0d want 0 and 1", tick, tick_cnt);
        end
        run = 0;
        $display("test_normal_rate done: time=%h", now_t);
    endtask

    task automatic test_year_wrap;
        set_ld(23, 59, 59, 31, 12, 99);
        load = 1; fast = 1; run = 1;
        step(1);
        load = 0; tick_cnt = 0;
        checks++;
        if (now_t !== pk(23, 59, 59, 31, 12, 99) || tick !== 1'b0) begin
            errors++; $display("FAIL wrap_load: got %h tick=%b want %h tick=0", now_t, tick, pk(23, 59, 59, 31, 12, 99));
        end
        step(3);
        checks++;
        if (now_t !== pk(23, 59, 59, 31, 12, 99)) begin
            errors++; $display("FAIL wrap_early: got %h want %h", now_t, pk(23, 59, 59, 31, 12, 99));
        end
        step(1);
        checks++;
        if (now_t !== pk(0, 0, 0, 1, 1, 0) || tick !== 1'b1) begin
            errors++; $display("FAIL wrap_rollover: got %h tick=%b want %h tick=1", now_t, tick, pk(0, 0, 0, 1, 1, 0));
        end
        step(1);
        checks++;
        if (tick_cnt != 1) begin
            errors++; $display("FAIL wrap_tick_count: got %0d want 1", tick_cnt);
        end
        $display("test_year_wrap done: time=%h", now_t);
    endtask

    task automatic test_leap;
        logic lp_load [3] = '{1'b1, 1'b0, 1'b1};
        logic lp_run  [3] = '{1'b1, 1'b0, 1'b0};
        int   d_load  [3] = '{28, 28, 29};
        int   d_exp   [3] = '{29, 1, 1};
        int   m_exp   [3] = '{2, 3, 3};
        fast = 1; run = 1;
        for (int i = 0; i < 3; i++) begin
            leap_en = lp_load[i];
            set_ld(23, 59, 59, d_load[i], 2, 4);
            load = 1;
            step(1);
            load = 0; leap_en = lp_run[i];
            checks++;
            if (now_t !== pk(23, 59, 59, d_load[i], 2, 4) || load_err !== 1'b0) begin
                errors++; $display("FAIL leap_load%0d: got %h err=%b want %h err=0", i, now_t, load_err, pk(23, 59, 59, d_load[i], 2, 4));
            end
            step(4);
            checks++;
            if (now_t !== pk(0, 0, 0, d_exp[i], m_exp[i], 4)) begin
                errors++; $display("FAIL leap_case%0d: got %h want %h", i, now_t, pk(0, 0, 0, d_exp[i], m_exp[i], 4));
            end
            $display("test_leap case %0d: time=%h", i, now_t);
        end
        leap_en = 0;
    endtask

    task automatic test_bad_load;
        int bd [3] = '{31, 1, 1};
        int bm [3] = '{4, 13, 1};
        int bs [3] = '{0, 0, 60};
        fast = 1; run = 1; leap_en = 1;
        for (int i = 0; i < 3; i++) begin
            set_ld(10, 0, 0, 15, 6, 5);
            load = 1;
            step(1);
            load = 0;
            step(2);
            set_ld(10, 0, bs[i], bd[i], bm[i], 5);
            load = 1;
            step(1);
            load = 0;
            checks++;
            if (load_err !== 1'b1 || now_t !== pk(10, 0, 0, 15, 6, 5)) begin
                errors++; $display("FAIL bad_load%0d: got err=%b %h want err=1 %h", i, load_err, now_t, pk(10, 0, 0, 15, 6, 5));
            end
            step(1);
            checks++;
            if (load_err !== 1'b0 || now_t !== pk(10, 0, 1, 15, 6, 5) || tick !== 1'b1) begin
                errors++; $display("FAIL bad_keep_count%0d: got err=%b %h tick=%b want err=0 %h tick=1", i, load_err, now_t, tick, pk(10, 0, 1, 15, 6, 5));
            end
            $display("test_bad_load case %0d: time=%h", i, now_t);
        end
    endtask

    task automatic test_hold;
        fast = 0; run = 1;
        set_ld(23, 59, 59, 30, 4, 7);
        load = 1;
        step(1);
        load = 0; run = 0; tick_cnt = 0;
        step(100);
        checks++;
        if (now_t !== pk(23, 59, 59, 30, 4, 7) || tick_cnt != 0) begin
            errors++; $display("FAIL hold: got %h ticks=%0d want %h ticks=0", now_t, tick_cnt, pk(23, 59, 59, 30, 4, 7));
        end
        run = 1;
        step(19);
        checks++;
        if (now_t !== pk(23, 59, 59, 30, 4, 7)) begin
            errors++; $display("FAIL hold_resume_early: got %h want %h", now_t, pk(23, 59, 59, 30, 4, 7));
        end
        step(1);
        checks++;
        if (now_t !== pk(0, 0, 0, 1, 5, 7) || tick !== 1'b1) begin
            errors++; $display("FAIL hold_resume: got %h tick=%b want %h tick=1", now_t, tick, pk(0, 0, 0, 1, 5, 7));
        end
        $display("test_hold done: time=%h", now_t);
    endtask

    task automatic test_reset_mid;
        fast = 0; run = 1;
        set_ld(1, 2, 3, 4, 5, 6);
        load = 1;
        step(1);
        load = 0;
        step(10);
        set_ld(12, 34, 56, 7, 8, 9);
        reset = 1; load = 1;
        step(1);
        checks++;
        if (now_t !== pk(0, 0, 0, 1, 1, 0) || tick !== 1'b0 || load_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got %h tick=%b err=%b want %h 0 0", now_t, tick, load_err, pk(0, 0, 0, 1, 1, 0));
        end
        reset = 0; load = 0; tick_cnt = 0;
        step(19);
        checks++;
        if (now_t !== pk(0, 0, 0, 1, 1, 0) || tick_cnt != 0) begin
            errors++; $display("FAIL reset_mid_early: got %h ticks=%0d want %h ticks=0", now_t, tick_cnt, pk(0, 0, 0, 1, 1, 0));
        end
        step(1);
        checks++;
        if (now_t !== pk(0, 0, 1, 1, 1, 0) || tick !== 1'b1) begin
            errors++; $display("FAIL reset_mid_adv: got %h tick=%b want %h tick=1", now_t, tick, pk(0, 0, 1, 1, 1, 0));
        end
        $display("test_reset_mid done: time=%h", now_t);
    endtask

    initial begin
        test_reset;
        test_normal_rate;
        test_year_wrap;
        test_leap;
        test_bad_load;
        test_hold;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
